// File: rtl/display_pkg.sv
// Shared definitions for the display source selector: blank nibble default,
// selector state encoding and flat-bus nibble indexing.
package display_pkg;

   localparam logic [3:0] DEFAULT_BLANK_CODE = 4'hF;

   typedef enum logic [0:0] {
      SHOW  = 1'b0,
      BLANK = 1'b1
   } state_t;

   // Bit offset of digit `digit` of source `src` in a flat {src_n-1 .. src_0} bus.
   function automatic int unsigned nib_lsb(input int unsigned src,
                                           input int unsigned digit,
                                           input int unsigned digits);
      return (src * digits + digit) * 4;
   endfunction

endpackage

// File: rtl/display_source_sel_blink_timer.sv
// Blink timebase: counts ticks and toggles the blink phase every BLINK_TICKS
// ticks; clr restarts the period in the visible phase.
module blink_timer #(
   parameter int BLINK_TICKS = 250
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic clr,
   output logic phase
);

   localparam int CW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (clr) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (tick) begin
         if (cnt == CW'(BLINK_TICKS - 1)) begin
            cnt   <= '0;
            phase <= ~phase;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/display_source_sel.sv
// Registered display source selector with post-switch blanking, per-digit
// blink for set modes and a freeze (lap hold) input.
module display_source_sel
   import display_pkg::*;
#(
   parameter int         NUM_SRC     = 4,
   parameter int         DIGITS      = 4,
   parameter int         SEL_W       = 2,
   parameter int         BLINK_TICKS = 250,
   parameter int         BLANK_TICKS = 2,
   parameter logic [3:0] BLANK_CODE  = DEFAULT_BLANK_CODE
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         tick,
   input  logic [SEL_W-1:0]             mode,
   input  logic [NUM_SRC*DIGITS*4-1:0]  src_bcd,
   input  logic [NUM_SRC-1:0]           blink_en,
   input  logic [DIGITS-1:0]            blink_mask,
   input  logic                         freeze,
   output logic [DIGITS*4-1:0]          out_bcd,
   output logic [SEL_W-1:0]             mode_active,
   output logic                         switching
);

   localparam int DW = DIGITS * 4;
   localparam int BW = (BLANK_TICKS > 0) ? $clog2(BLANK_TICKS + 1) : 1;

   state_t         state;
   logic [BW-1:0]  bcnt;
   logic           phase;
   logic           mode_valid;
   logic           do_switch;
   logic [DW-1:0]  disp_val;
   logic [DW-1:0]  blank_val;

   assign blank_val  = {DIGITS{BLANK_CODE}};
   assign mode_valid = (32'(mode) < 32'(NUM_SRC));
   assign do_switch  = mode_valid && (mode != mode_active);

   // A switch clears the blink timer so the new source starts visible.
   blink_timer #(
      .BLINK_TICKS(BLINK_TICKS)
   ) u_blink (
      .clk  (clk),
      .rst  (rst),
      .tick (tick),
      .clr  (do_switch),
      .phase(phase)
   );

   always_comb begin
      disp_val = '0;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (blink_en[mode_active] && phase && blink_mask[d])
            disp_val[d*4 +: 4] = BLANK_CODE;
         else
            disp_val[d*4 +: 4] = src_bcd[nib_lsb(32'(mode_active), d, DIGITS) +: 4];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= SHOW;
         bcnt        <= '0;
         out_bcd     <= blank_val;
         mode_active <= '0;
         switching   <= 1'b0;
      end else if (do_switch) begin
         mode_active <= mode;
         if (BLANK_TICKS > 0) begin
            state     <= BLANK;
            bcnt      <= BW'(BLANK_TICKS);
            switching <= 1'b1;
            out_bcd   <= blank_val;
         end else begin
            state   <= SHOW;
            out_bcd <= disp_val;
         end
      end else begin
         case (state)
            BLANK: begin
               out_bcd <= blank_val;
               if (tick) begin
                  bcnt <= bcnt - 1'b1;
                  // Leaving blank loads the source on the same clock.
                  if (bcnt == BW'(1)) begin
                     state     <= SHOW;
                     switching <= 1'b0;
                     out_bcd   <= disp_val;
                  end
               end
            end
            default: begin
               if (!freeze)
                  out_bcd <= disp_val;
            end
         endcase
      end
   end

endmodule
